// File: rtl/rf_wport_arbiter_if.sv
// Write-port arbiter bundle: pipeline/long-latency requests, ID hazard lookup, RF and debug write-back.
// slave = arbiter side, master = requesters / RF / ID side.
interface rf_wport_arbiter_if;
  logic        wb_req_valid;
  logic [4:0]  wb_req_addr;
  logic [31:0] wb_req_data;
  logic [31:0] wb_req_pc;
  logic        wb_req_ready;

  logic        lu_req_valid;
  logic [4:0]  lu_req_addr;
  logic [31:0] lu_req_data;
  logic [31:0] lu_req_pc;
  logic        lu_req_ready;

  logic [4:0]  query_addr0;
  logic [4:0]  query_addr1;
  logic [1:0]  query_hit;
  logic        lu_pending;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport slave (
    input  wb_req_valid, wb_req_addr, wb_req_data, wb_req_pc,
    input  lu_req_valid, lu_req_addr, lu_req_data, lu_req_pc,
    input  query_addr0, query_addr1,
    output wb_req_ready, lu_req_ready, query_hit, lu_pending,
    output rf_we, rf_waddr, rf_wdata,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output wb_req_valid, wb_req_addr, wb_req_data, wb_req_pc,
    output lu_req_valid, lu_req_addr, lu_req_data, lu_req_pc,
    output query_addr0, query_addr1,
    input  wb_req_ready, lu_req_ready, query_hit, lu_pending,
    input  rf_we, rf_waddr, rf_wdata,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB and a FIFO of long-latency results.
// Latency: WB write same cycle (combinational grant); LU result written at earliest one cycle after enqueue.
// Backpressure: lu_req_ready=~full; wb_req_ready drops only on a forced head grant (RFW_STARVE_GUARD_EN).
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               resetn,
  rf_wport_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } lu_entry_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
    $error("rf_wport_arbiter: unsupported FIFO_DEPTH or STARVE_LIMIT");
  end

  lu_entry_t           mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         fill;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                force_head;
  logic                grant_wb;
  logic                grant_lu;
  lu_entry_t           head;
  lu_entry_t           sel;
  logic                we;
  logic [FIFO_DEPTH-1:0] slot_vld;
  logic [FIFO_DEPTH-1:0] hit0;
  logic [FIFO_DEPTH-1:0] hit1;

  assign fill  = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign head  = mem[rd_ptr[AW-1:0]];

`ifdef RFW_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign force_head = (starve_cnt == LIMIT) && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (empty || grant_lu) begin
      starve_cnt <= '0;
    end else if (grant_wb && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_head = 1'b0;
`endif

  // Every grant is masked in reset so the RF and debug port stay quiet.
  assign grant_wb = resetn && bus.wb_req_valid && !force_head;
  assign grant_lu = resetn && !grant_wb && !empty;
  assign pop      = grant_lu;
  assign push     = bus.lu_req_valid && !full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.lu_req_addr, bus.lu_req_data, bus.lu_req_pc};
    end
  end

  always_comb begin
    sel = '0;
    if (grant_wb) begin
      sel = {bus.wb_req_addr, bus.wb_req_data, bus.wb_req_pc};
    end else if (grant_lu) begin
      sel = head;
    end
  end

  // r0 targets still consume their grant; they just never assert the write enable.
  assign we = (grant_wb || grant_lu) && (sel.addr != 5'd0);

  for (genvar k = 0; k < FIFO_DEPTH; k++) begin : g_slot
    logic [AW-1:0] off;
    assign off         = AW'(k) - rd_ptr[AW-1:0];
    assign slot_vld[k] = ({1'b0, off} < fill);
    assign hit0[k]     = slot_vld[k] && (mem[k].addr == bus.query_addr0);
    assign hit1[k]     = slot_vld[k] && (mem[k].addr == bus.query_addr1);
  end

  assign bus.query_hit[0] = resetn && (|hit0) && (bus.query_addr0 != 5'd0);
  assign bus.query_hit[1] = resetn && (|hit1) && (bus.query_addr1 != 5'd0);
  assign bus.lu_pending   = resetn && !empty;
  assign bus.lu_req_ready = resetn && !full;
  assign bus.wb_req_ready = resetn && !force_head;

  assign bus.rf_we             = we;
  assign bus.rf_waddr          = sel.addr;
  assign bus.rf_wdata          = sel.data;
  assign bus.debug_wb_pc       = sel.pc;
  assign bus.debug_wb_rf_wen   = {4{we}};
  assign bus.debug_wb_rf_wnum  = sel.addr;
  assign bus.debug_wb_rf_wdata = sel.data;
endmodule
